// File: rtl/gstmcu_vaddr_cnt.sv
// Video display address counter: CPU-visible screen base, line width and live
// word counter, reloaded at vertical sync and advanced by fetch/line strobes.
module gstmcu_vaddr_cnt #(
    parameter int unsigned AW      = 22,
    parameter int unsigned LW_BITS = 8
) (
    input  logic          c,
    input  logic          r,
    input  logic          ste,
    input  logic [2:0]    reg_sel,
    input  logic          reg_wr,
    input  logic [7:0]    reg_din,
    output logic [7:0]    reg_dout,
    input  logic          vsync_ld,
    input  logic          fetch,
    input  logic          line_end,
    output logic [AW-1:0] vaddr
);

    typedef logic [AW-1:0] addr_t;

    addr_t              base;
    addr_t              cnt;
    logic [LW_BITS-1:0] lw;

    addr_t              base_nxt;
    addr_t              cnt_nxt;
    logic [LW_BITS-1:0] lw_eff;
    logic [LW_BITS:0]   line_words;
    addr_t              line_inc;
    logic [23:0]        base_x;
    logic [23:0]        cnt_x;

    // Byte views zero-extended to 24 bits so unused upper address bits read 0.
    assign base_x = 24'(base);
    assign cnt_x  = 24'(cnt);

    assign lw_eff     = ste ? lw : '0;
    assign line_words = {1'b0, lw_eff} + {{LW_BITS{1'b0}}, fetch};
    assign line_inc   = addr_t'({line_words, 1'b0});

    always_comb begin
        base_nxt = base;
        if (reg_wr) begin
            case (reg_sel)
                3'd0: base_nxt[AW-1:16] = reg_din[AW-17:0];
                3'd1: base_nxt[15:8]    = reg_din;
                3'd2: if (ste) base_nxt[7:0] = reg_din & 8'hFE;
                default: ;
            endcase
        end
    end

    // Priority: vsync load, then STE byte write (drops strobes), then line, then fetch.
    always_comb begin
        cnt_nxt = cnt;
        if (vsync_ld) begin
            cnt_nxt = {base[AW-1:8], (ste ? base[7:0] : 8'h00)} & ~addr_t'(1);
        end else if (reg_wr && ste && (reg_sel == 3'd3 || reg_sel == 3'd4 || reg_sel == 3'd5)) begin
            case (reg_sel)
                3'd3:    cnt_nxt[AW-1:16] = reg_din[AW-17:0];
                3'd4:    cnt_nxt[15:8]    = reg_din;
                default: cnt_nxt[7:0]     = reg_din & 8'hFE;
            endcase
        end else if (line_end) begin
            cnt_nxt = cnt + line_inc;
        end else if (fetch) begin
            cnt_nxt = cnt + addr_t'(2);
        end
    end

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            base <= '0;
            cnt  <= '0;
            lw   <= '0;
        end else begin
            base <= base_nxt;
            cnt  <= cnt_nxt;
            if (reg_wr && ste && reg_sel == 3'd6)
                lw <= reg_din[LW_BITS-1:0];
        end
    end

    always_comb begin
        reg_dout = '0;
        case (reg_sel)
            3'd0: reg_dout = base_x[23:16];
            3'd1: reg_dout = base_x[15:8];
            3'd2: reg_dout = ste ? (base_x[7:0] & 8'hFE) : 8'h00;
            3'd3: reg_dout = cnt_x[23:16];
            3'd4: reg_dout = cnt_x[15:8];
            3'd5: reg_dout = cnt_x[7:0] & 8'hFE;
            3'd6: reg_dout = ste ? 8'(lw) : 8'h00;
            default: reg_dout = '0;
        endcase
    end

    assign vaddr = cnt;

endmodule

// File: doc/gstmcu_vaddr_cnt.md
Name: gstmcu_vaddr_cnt

Overview:
Video display address counter for the GSTMCU video path. It consumes the word-fetch and line timing strobes produced by the timing counter chains. It holds the CPU-programmable screen base and line-width registers, reloads the counter at vertical sync, and presents the current word address to the DMA/RAM arbiter. Byte-wide CPU register access is provided for read and, in STE mode, write.

Parameters:
AW, 22, address width in bits; bit 0 is always 0 (word addressing).
LW_BITS, 8, width of the line-width (extra words per line) register.

Ports:
c  input  1  clock; all state updates on posedge c.
r  input  1  asynchronous active-high reset.
ste  input  1  1 = STE feature set (low byte and counter writable, line width active); 0 = ST.
reg_sel  input  3  CPU register select.
reg_wr  input  1  CPU byte write strobe, one cycle wide.
reg_din  input  8  CPU write data.
reg_dout  output  8  CPU read data, combinational from reg_sel.
vsync_ld  input  1  one-cycle pulse; load counter from base.
fetch  input  1  one-cycle pulse; one video word consumed.
line_end  input  1  one-cycle pulse; end of displayed line.
vaddr  output  AW  current video word address; bit 0 is always 0.

Behaviour:
- Register map (reg_sel):
  - 0: base[AW-1:16], unused upper bits read 0.
  - 1: base[15:8].
  - 2: base[7:1], bit 0 reads 0. Writes ignored when ste=0; reads 0 when ste=0.
  - 3: cnt[AW-1:16].
  - 4: cnt[15:8].
  - 5: cnt[7:1].
  - 6: line width lw.
  - 7: reserved; reads 0, writes ignored.
- Counter writes (sel 3/4/5) and lw writes are honoured only when ste=1. With ste=0 they are read-only, and lw reads 0 and acts as 0.
- Reset (r=1, async): base, cnt and lw clear to 0; vaddr=0; reg_dout reflects the cleared registers. Reset mid-line discards any pending increment. The first posedge after r falls performs normal operation.
- Base writes take effect on the next posedge. They never disturb cnt until the next vsync_ld.
- Counter update on posedge c, first matching rule wins:
  1. vsync_ld: cnt <= base. Bit 0 is forced 0. In ST mode base[7:1] is taken as 0.
  2. reg_wr to sel 3/4/5 (ste=1): only the addressed byte of cnt is replaced; other bytes are held. A coincident fetch or line_end is dropped.
  3. line_end: cnt <= cnt + 2*(lw + fetch). A coincident fetch is added in the same cycle.
  4. fetch: cnt <= cnt + 2.
  5. Otherwise cnt holds.
- All arithmetic is modulo 2^AW. Wrap from all-ones-word to 0 is silent.
- A base write coincident with vsync_ld: the load uses the old base value; the new value is stored for the next load.
- Latency: vaddr = cnt (registered). A fetch pulse in cycle n is visible on vaddr in cycle n+1.
- reg_dout is purely combinational from reg_sel and the current registers. A read in the same cycle as an update returns the pre-update value.
- Toggling ste takes effect immediately for decode. Stored lw and base low bits are retained but masked while ste=0.
- No internal state machine beyond the registers. No stall or handshake: every strobe is accepted in the cycle it is asserted.

Test Plan:
1. Reset then ST base: assert r, release; check vaddr=0, all reads 0. With ste=0 write sel0=0x07, sel1=0x80, sel2=0xFE, then pulse vsync_ld. Require vaddr=0x078000, and sel2 reads 0.
2. Fetch increments: from 0x078000, issue 80 fetch pulses. Require vaddr=0x0780A0, with each step visible one cycle after its pulse.
3. STE line width: ste=1, base 0x010000, lw=4, vsync_ld. Issue 3 fetches, then line_end coincident with a fetch. Require 0x010006 after the fetches and 0x010010 after line_end (+2*(4+1)).
4. Counter byte write priority: ste=1, cnt=0x0123FE. reg_wr sel5=0x10 coincident with fetch. Require vaddr=0x012310 and the fetch dropped. The same write with ste=0 leaves vaddr=0x012400 (fetch applied).
5. Wrap and simultaneous vsync: cnt=0x3FFFFE, fetch gives 0x000000. Then vsync_ld coincident with a base sel1 write of 0x55 when old base=0x020000: require vaddr=0x020000, and the next vsync_ld gives 0x025500.
6. Async reset mid-operation: with fetches running, assert r between clock edges. Require vaddr=0 immediately, not at the next edge, and registers cleared.
